// File: rtl/scan_chain_ctrl.sv
// Scan-chain load/capture/unload controller with overlapped unload of the previous capture.
// Optional expected-response compare is enabled by defining SCAN_CMP_EN.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 7
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 pat_valid,
    input  logic [CHAIN_LEN-1:0] pat_data,
    output logic                 pat_ready,
    output logic                 SE,
    output logic                 SI,
    input  logic                 SO,
    output logic                 resp_valid,
    output logic [CHAIN_LEN-1:0] resp_data,
    output logic                 busy
`ifdef SCAN_CMP_EN
    ,
    input  logic [CHAIN_LEN-1:0] exp_data,
    input  logic [CHAIN_LEN-1:0] exp_mask,
    output logic                 mismatch
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, FLUSH} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   first_q;
    logic [CHAIN_LEN-1:0]   pat_q;
    logic [CHAIN_LEN-2:0]   resp_sr_q;
    logic [CHAIN_LEN-1:0]   resp_data_q;
    logic                   resp_valid_q;
    logic                   se_q;
    logic                   si_q;
    logic                   ready_q;
    logic                   busy_q;

    logic                   accept_d;
    logic                   shift_end_d;
    logic                   flush_end_d;
    logic [CHAIN_LEN-1:0]   resp_next_d;

    assign accept_d    = pat_valid && ready_q;
    assign shift_end_d = (state_q == SHIFT) && (cnt_q == LAST);
    assign flush_end_d = (state_q == FLUSH) && (cnt_q == LAST);
    // Full response including the SO bit sampled on this edge.
    assign resp_next_d = {resp_sr_q, SO};

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            first_q      <= 1'b1;
            pat_q        <= '0;
            resp_sr_q    <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            se_q         <= 1'b0;
            si_q         <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            if (se_q) begin
                resp_sr_q <= resp_next_d[CHAIN_LEN-2:0];
            end
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept_d) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        first_q <= 1'b1;
                        se_q    <= 1'b1;
                        si_q    <= pat_data[CHAIN_LEN-1];
                        pat_q   <= {pat_data[CHAIN_LEN-2:0], 1'b0};
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (shift_end_d) begin
                        state_q      <= CAPTURE;
                        cnt_q        <= '0;
                        se_q         <= 1'b0;
                        si_q         <= 1'b0;
                        ready_q      <= 1'b1;
                        first_q      <= 1'b0;
                        // The very first unload after IDLE carries undefined chain contents.
                        resp_valid_q <= !first_q;
                        if (!first_q) begin
                            resp_data_q <= resp_next_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        si_q  <= pat_q[CHAIN_LEN-1];
                        pat_q <= {pat_q[CHAIN_LEN-2:0], 1'b0};
                    end
                end
                CAPTURE: begin
                    cnt_q   <= '0;
                    se_q    <= 1'b1;
                    ready_q <= 1'b0;
                    if (accept_d) begin
                        state_q <= SHIFT;
                        si_q    <= pat_data[CHAIN_LEN-1];
                        pat_q   <= {pat_data[CHAIN_LEN-2:0], 1'b0};
                    end else begin
                        state_q <= FLUSH;
                        si_q    <= 1'b0;
                    end
                end
                FLUSH: begin
                    si_q <= 1'b0;
                    if (flush_end_d) begin
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        se_q         <= 1'b0;
                        ready_q      <= 1'b1;
                        busy_q       <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= resp_next_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    se_q    <= 1'b0;
                    si_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pat_ready  = ready_q;
    assign SE         = se_q;
    assign SI         = si_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = busy_q;

`ifdef SCAN_CMP_EN
    logic [CHAIN_LEN-1:0] exp_cur_q;
    logic [CHAIN_LEN-1:0] mask_cur_q;
    logic [CHAIN_LEN-1:0] exp_prev_q;
    logic [CHAIN_LEN-1:0] mask_prev_q;
    logic                 mismatch_q;

    // A SHIFT unload belongs to the previous pattern, a FLUSH unload to the latest one.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            exp_cur_q   <= '0;
            mask_cur_q  <= '0;
            exp_prev_q  <= '0;
            mask_prev_q <= '0;
            mismatch_q  <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            if (accept_d && (state_q == IDLE || state_q == CAPTURE)) begin
                exp_prev_q  <= exp_cur_q;
                mask_prev_q <= mask_cur_q;
                exp_cur_q   <= exp_data;
                mask_cur_q  <= exp_mask;
            end
            if (shift_end_d && !first_q) begin
                mismatch_q <= |((resp_next_d ^ exp_prev_q) & mask_prev_q);
            end else if (flush_end_d) begin
                mismatch_q <= |((resp_next_d ^ exp_cur_q) & mask_cur_q);
            end
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 16: number of SDFF cells in the driven scan chain; legal range 2..64.
REQ-002 Parameter CNT_W, default 7: shift-counter width; SHALL satisfy 2^CNT_W > CHAIN_LEN.
REQ-003 CK  input  1  single clock; all state updates on posedge CK.
REQ-004 RN  input  1  asynchronous active-low reset.
REQ-005 pat_valid  input  1  test pattern available on pat_data.
REQ-006 pat_data  input  CHAIN_LEN  pattern to load; bit i targets chain cell i (cell 0 nearest SI).
REQ-007 pat_ready  output  1  pattern accepted on a cycle where pat_valid && pat_ready.
REQ-008 SE  output  1  registered scan enable to every chain cell.
REQ-009 SI  output  1  registered serial data to chain cell 0.
REQ-010 SO  input  1  serial output of chain cell CHAIN_LEN-1.
REQ-011 resp_valid  output  1  one-cycle pulse: resp_data holds one unloaded capture response.
REQ-012 resp_data  output  CHAIN_LEN  unloaded response; bit i = value captured by cell i.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, CAPTURE, FLUSH.
REQ-015 pat_ready SHALL be high only in IDLE and in CAPTURE.
REQ-016 IDLE: pattern accept -> SHIFT; counter cleared; first_pat flag set.
REQ-017 SHIFT: SE=1 for exactly CHAIN_LEN consecutive cycles; SI order: pat_data[CHAIN_LEN-1] first, pat_data[0] last.
REQ-018 On each closing CK edge of a SE=1 cycle, the controller SHALL sample SO into resp shift register: resp <= {resp[CHAIN_LEN-2:0], SO}.
REQ-019 After CHAIN_LEN SHIFT cycles -> CAPTURE; SE=0 for exactly one cycle, SI=0.
REQ-020 CAPTURE with pattern accept -> SHIFT (next pattern; overlapped unload of previous capture); without accept -> FLUSH.
REQ-021 FLUSH: SE=1, SI=0 for CHAIN_LEN cycles, unloading the last capture; then -> IDLE.
REQ-022 resp_valid SHALL pulse on the cycle after the last SO sample of any SHIFT or FLUSH phase, except the first SHIFT after IDLE (first_pat set: chain contents undefined, response discarded; first_pat then cleared).
REQ-023 resp_data SHALL hold its value until the next resp_valid pulse.
REQ-024 Patterns accepted N SHALL produce exactly N resp_valid pulses, in acceptance order.
REQ-025 pat_valid deasserting mid-SHIFT SHALL have no effect; pattern is latched at acceptance.
REQ-026 Counter SHALL wrap to 0 at each phase end; no off-by-one at CHAIN_LEN=2.
REQ-027 SE/SI SHALL be glitch-free flop outputs; no combinational path from any input to SE/SI.

Reset
REQ-028 RN low SHALL immediately force: state IDLE, SE=0, SI=0, pat_ready=0 until first edge after release, resp_valid=0, resp_data=0, busy=0, counter=0, first_pat=1.
REQ-029 Reset mid-SHIFT/FLUSH SHALL abort without any resp_valid pulse; in-flight pattern is lost.

Configuration
REQ-030 Macro SCAN_CMP_EN: when defined, add inputs exp_data (CHAIN_LEN), exp_mask (CHAIN_LEN) latched with each pattern, and output mismatch (1) asserted with resp_valid when (resp_data ^ exp_of_previous_pattern) & mask != 0; reset 0.
REQ-031 Without SCAN_CMP_EN: ports exp_data, exp_mask, mismatch SHALL not exist; no compare logic.

Verification
REQ-032 CHAIN_LEN=16, one pattern 0xA5C3, chain model captures D=~Q -> SE high 16 cycles, low 1, high 16 (FLUSH); one resp_valid, resp_data=0x5A3C; busy low after 34 cycles.
REQ-033 Three back-to-back patterns 0x0001,0x8000,0xFFFF with pat_valid held -> no FLUSH between; SE low once per pattern; 3 resp_valid pulses in order.
REQ-034 RN asserted on cycle 8 of SHIFT -> SE=0,SI=0 same cycle; no resp_valid; next pattern runs normally.
REQ-035 CHAIN_LEN=2, pattern 2'b10 -> SI sequence 1,0; CAPTURE 1 cycle; FLUSH 2 cycles.
REQ-036 SCAN_CMP_EN, exp=0x5A3C mask=0xFFFF -> mismatch=0; flip one chain capture bit -> mismatch=1 with resp_valid; mask that bit -> mismatch=0.
